// File: rtl/bcd_multi_converter.sv
// Multi-digit BCD converter: one digit per clock into excess-3, 2421, Gray or nine's complement.
// Optional macro BCD_CONV_PARITY_EN adds a per-digit parity output out_par.
module bcd_multi_converter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_code,
    output logic [DIGITS-1:0]     err_mask,
`ifdef BCD_CONV_PARITY_EN
    output logic [DIGITS-1:0]     out_par,
`endif
    output logic                  out_err
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [IDXW-1:0]       idx_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [1:0]            mode_q;
    logic [4*DIGITS-1:0]   code_q, code_d;
    logic [DIGITS-1:0]     err_q, err_d;
    logic                  out_err_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [3:0]            nib_in, nib_out;

    // Invalid digits map to 4'hF regardless of the selected code.
    function automatic logic [3:0] conv_digit(input logic [3:0] d, input logic [1:0] m);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'hF;
        end else begin
            case (m)
                2'b00:   r = d + 4'd3;
                2'b01:   r = (d >= 4'd5) ? d + 4'd6 : d;
                2'b10:   r = d ^ (d >> 1);
                default: r = 4'd9 - d;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        nib_in  = bcd_q[4*idx_q +: 4];
        nib_out = conv_digit(nib_in, mode_q);
        code_d  = code_q;
        code_d[4*idx_q +: 4] = nib_out;
        err_d   = err_q;
        err_d[idx_q] = (nib_in > 4'd9);
    end

`ifdef BCD_CONV_PARITY_EN
    logic [DIGITS-1:0] par_q, par_d;

    always_comb begin
        par_d = par_q;
        par_d[idx_q] = ^nib_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else if (state_q == IDLE && in_valid && in_ready_q) begin
            par_q <= '0;
        end else if (state_q == CONV) begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bcd_q       <= '0;
            mode_q      <= 2'b00;
            code_q      <= '0;
            err_q       <= '0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        bcd_q      <= in_bcd;
                        mode_q     <= mode;
                        code_q     <= '0;
                        err_q      <= '0;
                        out_err_q  <= 1'b0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    code_q    <= code_d;
                    err_q     <= err_d;
                    out_err_q <= |err_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_code  = code_q;
    assign err_mask  = err_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_multi_converter.sv
// Directed bench for bcd_multi_converter (DIGITS=4): conversions, latency, invalid digits,
// backpressure and mid-conversion reset.
module tb_bcd_multi_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_code;
    logic [3:0]  err_mask;
    logic        out_err;
`ifdef BCD_CONV_PARITY_EN
    logic [3:0]  out_par;
`endif

    int total = 0;
    int bad   = 0;

    bcd_multi_converter #(.DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bcd   (in_bcd),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code (out_code),
        .err_mask (err_mask),
`ifdef BCD_CONV_PARITY_EN
        .out_par  (out_par),
`endif
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one word, check latency and result, then consume it.
    task automatic run_word(input string tag, input logic [1:0] m, input logic [15:0] bcd,
                            input logic [15:0] exp_code, input logic [3:0] exp_err);
        int cnt;
        @(negedge clk);
        chk({tag, "_rdy_before"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_bcd   = bcd;
        mode     = m;
        @(negedge clk);
        in_valid = 1'b0;
        in_bcd   = 16'hFFFF;
        mode     = ~m;
        chk({tag, "_rdy_after_accept"}, {31'd0, in_ready}, 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 32'd4);
        chk({tag, "_code"}, {16'd0, out_code}, {16'd0, exp_code});
        chk({tag, "_err_mask"}, {28'd0, err_mask}, {28'd0, exp_err});
        chk({tag, "_out_err"}, {31'd0, out_err}, {31'd0, |exp_err});
`ifdef BCD_CONV_PARITY_EN
        chk({tag, "_par"}, {28'd0, out_par},
            {28'd0, ^exp_code[15:12], ^exp_code[11:8], ^exp_code[7:4], ^exp_code[3:0]});
`endif
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = 16'h0000;
        mode      = 2'b00;
        out_ready = 1'b0;

        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_code", {16'd0, out_code}, 32'd0);
        chk("rst_err_mask", {28'd0, err_mask}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

        run_word("xs3", 2'b00, 16'h1209, 16'h453C, 4'b0000);
        consume("xs3");
        run_word("c2421", 2'b01, 16'h5678, 16'hBCDE, 4'b0000);
        consume("c2421");
        run_word("gray", 2'b10, 16'h0937, 16'h0D24, 4'b0000);
        consume("gray");

        run_word("inval", 2'b00, 16'h1A2F, 16'h4F5F, 4'b0101);
        // Backpressure: five cycles with out_ready low, word held.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_code", {16'd0, out_code}, 32'h0000_4F5F);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        consume("inval");

        // err_mask must be cleared by the next acceptance.
        run_word("nines", 2'b11, 16'h9180, 16'h0819, 4'b0000);
        consume("nines");

        // Reset in the middle of a conversion.
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = 16'h1234;
        mode     = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_partial_code", {16'd0, out_code}, 32'h0000_0007);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code", {16'd0, out_code}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_err", {28'd0, err_mask}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("mid_rel_in_ready_high", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_no_valid", {31'd0, out_valid}, 32'd0);
        end

        // Word accepted cleanly after reset recovery.
        run_word("post_rst", 2'b10, 16'h9999, 16'hDDDD, 4'b0000);
        consume("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
